multi_edge_counter: RTL

//  Parametrised multi-channel edge counter; next generation of the single-channel rising-edge counter.
//  Per channel: synchronises an async input, detects rising/falling/both edges (runtime-selectable),

---
 rtl/edge_counter_pkg.sv | 9 +
 rtl/edge_counter_channel.sv | 101 ++++++++++
 rtl/multi_edge_counter.sv | 86 ++++++++
 3 files changed

// File: rtl/edge_counter_pkg.sv
// Shared definitions for the multi-channel edge counter: per-channel edge mode encodings.
package edge_counter_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

endpackage

// File: rtl/edge_counter_channel.sv
// One edge-counter channel: input synchroniser, mode-selected edge detector,
// saturating or wrapping counter and sticky overflow flag.
module edge_counter_channel
    import edge_counter_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter bit SATURATE    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig,
    input  logic [1:0]       mode,
    input  logic             clear,
    input  logic             arm,
    output logic             pulse,
    output logic [WIDTH-1:0] count,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   s_s;
    logic                   rise_s;
    logic                   fall_s;
    logic                   edge_s;
    logic [WIDTH-1:0]       count_r;
    logic [WIDTH-1:0]       count_nxt_s;
    logic                   ovf_r;
    logic                   ovf_nxt_s;
    logic                   pulse_r;

    assign s_s    = sync_r[SYNC_STAGES-1];
    assign rise_s = s_s & ~prev_r;
    assign fall_s = ~s_s & prev_r;

    // Qualify raw transitions by the live mode; nothing counts before the top arms us
    always_comb begin
        edge_s = 1'b0;
        if (arm) begin
            case (mode)
                MODE_OFF:  edge_s = 1'b0;
                MODE_RISE: edge_s = rise_s;
                MODE_FALL: edge_s = fall_s;
                MODE_BOTH: edge_s = rise_s | fall_s;
                default:   edge_s = 1'b0;
            endcase
        end else begin
            edge_s = 1'b0;
        end
    end

    // Next count/overflow; clear beats a coincident edge
    always_comb begin
        count_nxt_s = count_r;
        ovf_nxt_s   = ovf_r;
        if (clear) begin
            count_nxt_s = {WIDTH{1'b0}};
            ovf_nxt_s   = 1'b0;
        end else if (edge_s) begin
            if (count_r == CNT_MAX) begin
                ovf_nxt_s = 1'b1;
                if (SATURATE) begin
                    count_nxt_s = CNT_MAX;
                end else begin
                    count_nxt_s = {WIDTH{1'b0}};
                end
            end else begin
                count_nxt_s = count_r + CNT_ONE;
            end
        end else begin
            count_nxt_s = count_r;
            ovf_nxt_s   = ovf_r;
        end
    end

    // Synchroniser, edge history, strobe and counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r  <= {SYNC_STAGES{1'b0}};
            prev_r  <= 1'b0;
            pulse_r <= 1'b0;
            count_r <= {WIDTH{1'b0}};
            ovf_r   <= 1'b0;
        end else begin
            sync_r  <= {sync_r[SYNC_STAGES-2:0], sig};
            prev_r  <= s_s;
            pulse_r <= edge_s;
            count_r <= count_nxt_s;
            ovf_r   <= ovf_nxt_s;
        end
    end

    assign pulse    = pulse_r;
    assign count    = count_r;
    assign overflow = ovf_r;

endmodule

// File: rtl/multi_edge_counter.sv
// Multi-channel edge counter top: post-reset arming, NUM_CH independent channels
// and a registered read port for the selected channel's count.
module multi_edge_counter
    import edge_counter_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter bit SATURATE    = 1'b1,
    localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                in_clock,
    input  logic                in_reset,
    input  logic [NUM_CH-1:0]   in_signal,
    input  logic [2*NUM_CH-1:0] in_mode,
    input  logic [NUM_CH-1:0]   in_clear,
    input  logic [SEL_W-1:0]    in_sel,
    output logic [NUM_CH-1:0]   out_pulse,
    output logic [WIDTH-1:0]    out_count,
    output logic [NUM_CH-1:0]   out_overflow
);

    localparam int ARM_N = SYNC_STAGES + 1;
    localparam int ARM_W = $clog2(ARM_N + 1);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(ARM_N);
    localparam logic [ARM_W-1:0] ARM_ONE  = {{(ARM_W-1){1'b0}}, 1'b1};
    localparam int SEL_N = 1 << SEL_W;

    logic [ARM_W-1:0] arm_cnt_r;
    logic             armed_s;
    logic [WIDTH-1:0] count_s    [NUM_CH];
    logic [WIDTH-1:0] read_tab_s [SEL_N];
    logic [WIDTH-1:0] out_count_r;

    assign armed_s = (arm_cnt_r == ARM_DONE);

    // Hold off edge detection until the sync chains have flushed their reset values
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            arm_cnt_r <= {ARM_W{1'b0}};
        end else if (!armed_s) begin
            arm_cnt_r <= arm_cnt_r + ARM_ONE;
        end else begin
            arm_cnt_r <= arm_cnt_r;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        edge_counter_channel #(
            .WIDTH       (WIDTH),
            .SYNC_STAGES (SYNC_STAGES),
            .SATURATE    (SATURATE)
        ) u_ch (
            .clk      (in_clock),
            .rst_n    (in_reset),
            .sig      (in_signal[g]),
            .mode     (in_mode[2*g+1:2*g]),
            .clear    (in_clear[g]),
            .arm      (armed_s),
            .pulse    (out_pulse[g]),
            .count    (count_s[g]),
            .overflow (out_overflow[g])
        );
    end

    // Selects beyond the last channel read as zero
    for (genvar r = 0; r < SEL_N; r++) begin : g_rd
        if (r < NUM_CH) begin : g_live
            assign read_tab_s[r] = count_s[r];
        end else begin : g_pad
            assign read_tab_s[r] = {WIDTH{1'b0}};
        end
    end

    // Registered read port
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            out_count_r <= {WIDTH{1'b0}};
        end else begin
            out_count_r <= read_tab_s[in_sel];
        end
    end

    assign out_count = out_count_r;

endmodule
